// File: rtl/led_shift_ctrl.sv
// LED pattern sequencer: advances an NB_LEDS-wide pattern once per rising edge of
// the tick strobe, in rotate-left, rotate-right, ping-pong or flash mode.
module led_shift_ctrl #(
  parameter int NB_LEDS = 4,
  parameter int NB_MODE = 2
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [NB_MODE-1:0] i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_wrap
);

  typedef enum logic [2:0] {
    SHL   = 3'd0,
    SHR   = 3'd1,
    PP_UP = 3'd2,
    PP_DN = 3'd3,
    FLASH = 3'd4
  } state_t;

  localparam logic [NB_LEDS-1:0] LED_ONE  = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] LED_ALL  = {NB_LEDS{1'b1}};

  state_t               state;
  state_t               state_nx;
  logic [NB_MODE-1:0]   mode_q;
  logic                 valid_q;
  logic                 step;
  logic [NB_LEDS-1:0]   led_nx;
  logic                 wrap_nx;
  logic [NB_LEDS-1:0]   led_shl;
  logic [NB_LEDS-1:0]   led_shr;

  // i_valid is a level strobe with no ready: only its rising edge, seen while
  // i_enable is high, is a step; a strobe held high steps once, a tick while
  // disabled is dropped and never replayed.
  assign step    = i_valid & ~valid_q & i_enable;
  assign led_shl = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
  assign led_shr = {o_led[0], o_led[NB_LEDS-1:1]};

  always_comb begin
    state_nx = state;
    led_nx   = o_led;
    wrap_nx  = 1'b0;
    if (step) begin
      if (i_mode != mode_q) begin
        // A mode change only reseeds; the pattern advances from the next step.
        case (i_mode)
          2'd0: begin led_nx = LED_ONE; state_nx = SHL;   end
          2'd1: begin led_nx = LED_ONE; state_nx = SHR;   end
          2'd2: begin led_nx = LED_ONE; state_nx = PP_UP; end
          default: begin led_nx = LED_ALL; state_nx = FLASH; end
        endcase
      end else begin
        case (state)
          SHL: begin
            led_nx  = led_shl;
            wrap_nx = o_led[NB_LEDS-1];
          end
          SHR: begin
            led_nx  = led_shr;
            wrap_nx = (led_shr == LED_ONE);
          end
          PP_UP: begin
            led_nx = led_shl;
            if (led_shl[NB_LEDS-1]) state_nx = PP_DN;
          end
          PP_DN: begin
            led_nx = led_shr;
            if (led_shr[0]) begin
              state_nx = PP_UP;
              wrap_nx  = 1'b1;
            end
          end
          FLASH: begin
            led_nx  = ~o_led;
            wrap_nx = (~o_led == LED_ALL);
          end
          default: begin
            led_nx   = LED_ONE;
            state_nx = SHL;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state   <= SHL;
      mode_q  <= '0;
      valid_q <= 1'b1;
      o_led   <= LED_ONE;
      o_wrap  <= 1'b0;
    end else begin
      state   <= state_nx;
      valid_q <= i_valid;
      o_led   <= led_nx;
      o_wrap  <= wrap_nx;
      if (step) mode_q <= i_mode;
    end
  end

endmodule
